pwm_source: RTL



---
 rtl/pwm_source_pkg.sv | 26 ++
 rtl/pwm_period_counter.sv | 63 ++++++
 rtl/pwm_source.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_source_pkg.sv
// -----------------------------------------------------------------------------
// pwm_source_pkg
// Shared types and constants for the PWM command source (pwm_source) and its
// period counter (pwm_period_counter).
//   state_e        : sequencer states (idle, run, reversal wait, reversal guard)
//   MIN_PERIOD     : smallest period the counter will run; shorter requests clamp
//   DEF_*          : default parameter values used by pwm_source
// -----------------------------------------------------------------------------
package pwm_source_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_REV_WAIT  = 2'd2,
        ST_REV_GUARD = 2'd3
    } state_e;

    // A period of 0 or 1 would leave no room for both a high and a low phase.
    localparam int MIN_PERIOD = 2;

    localparam int DEF_CNT_W     = 20;
    localparam int DEF_PERIOD    = 100000;  // 1 kHz at 100 MHz
    localparam int DEF_DUTY      = 50000;   // 50 %
    localparam int DEF_DIR_GUARD = 1000;

endpackage

// File: rtl/pwm_period_counter.sv
// -----------------------------------------------------------------------------
// pwm_period_counter
// Free-running period counter with period clamp, wrap detect and duty compare.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (cnt -> 0)
//   clear      : force cnt to 0 on the next edge (has priority over advance)
//   advance    : count one step; wraps to 0 after period-1
//   period     : requested period in cycles (values below MIN_PERIOD clamp)
//   duty       : high time in cycles
//   wrap       : cnt is on the last cycle of the period
//   cnt_zero   : cnt is on the first cycle of the period
//   duty_hit   : cnt < duty (PWM level for this count)
// -----------------------------------------------------------------------------
module pwm_period_counter
    import pwm_source_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    output logic             wrap,
    output logic             cnt_zero,
    output logic             duty_hit
);

    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period_eff;
    logic [CNT_W-1:0] last_cnt;

    always_comb begin
        period_eff = (period < MIN_P) ? MIN_P : period;
        last_cnt   = period_eff - CNT_W'(1);
        // >= rather than == so a count left beyond a shortened period still
        // wraps immediately instead of running round the whole counter range.
        wrap       = (cnt_q >= last_cnt);
        cnt_zero   = (cnt_q == '0);
        duty_hit   = (cnt_q < duty);

        if (clear) begin
            cnt_d = '0;
        end else if (advance) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_source.sv
// -----------------------------------------------------------------------------
// pwm_source
// Source end of the pwm_in/dir command pair for the deadtime H-bridge driver.
// Generates PWM from a double-buffered period/duty pair and sequences direction
// reversals so that dir never changes while PWM is high.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   enable        : 1 = run, 0 = idle (PWM low)
//   period_in     : requested period in cycles
//   duty_in       : requested high time in cycles
//   cfg_valid     : config write request
//   cfg_ready     : shadow free; write accepted on cfg_valid & cfg_ready
//   dir_req       : requested direction
//   pwm_out       : PWM to the driver
//   dir_out       : direction to the driver
//   period_start  : one-cycle pulse, aligned with the first PWM cycle of a period
//   rev_busy      : high while a reversal is waiting or guarding
// All outputs are registered; pwm_out and period_start lag the count by a cycle.
// -----------------------------------------------------------------------------
module pwm_source
    import pwm_source_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int DEFAULT_PERIOD = DEF_PERIOD,
    parameter int DEFAULT_DUTY   = DEF_DUTY,
    parameter int DIR_GUARD      = DEF_DIR_GUARD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] duty_in,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             dir_req,
    output logic             pwm_out,
    output logic             dir_out,
    output logic             period_start,
    output logic             rev_busy
);

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(DIR_GUARD - 1);
    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] RST_DUTY   = CNT_W'(DEFAULT_DUTY);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] guard_q, guard_d;
    logic             rev_idle_q, rev_idle_d;
    logic             dir_q, dir_d;
    logic             pwm_q, pwm_d;
    logic             ps_q, ps_d;
    logic             busy_q, busy_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] sh_period_q, sh_period_d;
    logic [CNT_W-1:0] sh_duty_q, sh_duty_d;

    logic cnt_clear, cnt_adv;
    logic wrap, cnt_zero, duty_hit;
    logic mismatch, apply, accept;

    pwm_period_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .advance  (cnt_adv),
        .period   (period_q),
        .duty     (duty_q),
        .wrap     (wrap),
        .cnt_zero (cnt_zero),
        .duty_hit (duty_hit)
    );

    always_comb begin
        state_d    = state_q;
        guard_d    = guard_q;
        rev_idle_d = rev_idle_q;
        dir_d      = dir_q;
        pwm_d      = 1'b0;
        ps_d       = 1'b0;
        cnt_clear  = 1'b1;
        cnt_adv    = 1'b0;
        mismatch   = (dir_req != dir_q);

        case (state_q)
            ST_IDLE: begin
                if (mismatch) begin
                    state_d    = ST_REV_GUARD;
                    guard_d    = '0;
                    rev_idle_d = 1'b1;
                end else if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_clear = 1'b0;
                    cnt_adv   = 1'b1;
                    ps_d      = cnt_zero;
                    if (mismatch) begin
                        // PWM goes low on the very next cycle.
                        state_d = ST_REV_WAIT;
                    end else begin
                        pwm_d = duty_hit;
                    end
                end
            end
            ST_REV_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_clear = 1'b0;
                    cnt_adv   = 1'b1;
                    if (wrap) begin
                        state_d    = ST_REV_GUARD;
                        guard_d    = '0;
                        rev_idle_d = 1'b0;
                    end
                end
            end
            ST_REV_GUARD: begin
                // A guard started from RUN is abandoned when enable drops. A
                // guard started from IDLE is the re-run of such a reversal and
                // must complete with enable low, otherwise IDLE and REV_GUARD
                // would alternate forever and dir could never change while idle.
                if (!enable && !rev_idle_q) begin
                    state_d = ST_IDLE;
                    guard_d = '0;
                end else if (guard_q == GUARD_LAST) begin
                    // Only the value sampled on the last guard cycle counts.
                    dir_d   = dir_req;
                    guard_d = '0;
                    state_d = enable ? ST_RUN : ST_IDLE;
                end else begin
                    guard_d = guard_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_REV_WAIT) || (state_d == ST_REV_GUARD);

        // Shadow handling. Apply and accept never coincide: accept needs an
        // empty shadow, apply needs a full one.
        apply  = !cfg_ready_q &&
                 ((state_q == ST_RUN && enable && wrap) ||
                  ((state_q == ST_IDLE || state_q == ST_REV_GUARD) && state_d == ST_RUN));
        accept = cfg_valid && cfg_ready_q;

        period_d    = period_q;
        duty_d      = duty_q;
        sh_period_d = sh_period_q;
        sh_duty_d   = sh_duty_q;
        cfg_ready_d = cfg_ready_q;
        if (apply) begin
            period_d    = sh_period_q;
            duty_d      = sh_duty_q;
            cfg_ready_d = 1'b1;
        end
        if (accept) begin
            sh_period_d = period_in;
            sh_duty_d   = duty_in;
            cfg_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            guard_q     <= '0;
            rev_idle_q  <= 1'b0;
            dir_q       <= 1'b0;
            pwm_q       <= 1'b0;
            ps_q        <= 1'b0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            period_q    <= RST_PERIOD;
            duty_q      <= RST_DUTY;
            sh_period_q <= '0;
            sh_duty_q   <= '0;
        end else begin
            state_q     <= state_d;
            guard_q     <= guard_d;
            rev_idle_q  <= rev_idle_d;
            dir_q       <= dir_d;
            pwm_q       <= pwm_d;
            ps_q        <= ps_d;
            busy_q      <= busy_d;
            cfg_ready_q <= cfg_ready_d;
            period_q    <= period_d;
            duty_q      <= duty_d;
            sh_period_q <= sh_period_d;
            sh_duty_q   <= sh_duty_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign dir_out      = dir_q;
    assign period_start = ps_q;
    assign rev_busy     = busy_q;
    assign cfg_ready    = cfg_ready_q;

endmodule
